scan_cmd_sequencer: RTL and testbench

//  Sequences beam-scan command words: fetches 24-bit words {Ctrl[7:0],Cnt[15:0]} from a command store/FIFO.

---
 rtl/scan_cmd_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_scan_cmd_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_cmd_sequencer.sv
// Beam-scan command sequencer: plays {ctrl,count} words onto the scan control bus with a one-word prefetch.
// Build macro SCAN_SEQ_LOOP_EN adds i_loop, which replays the list from the top instead of finishing.
module scan_cmd_sequencer #(
    parameter logic [7:0]  IDLE_CTRL = 8'h00,
    parameter int unsigned FETCH_TO  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_tick,
    input  logic [23:0] i_cmd_data,
    input  logic        i_cmd_valid,
`ifdef SCAN_SEQ_LOOP_EN
    input  logic        i_loop,
`endif
    output logic        o_cmd_ready,
    output logic        o_cmd_rewind,
    output logic [7:0]  o_ctrl_out,
    output logic [15:0] o_seg_remain,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RUN,
        ST_DONE
    } state_t;

    // The FETCH timer counts 0..FETCH_TO-1; FETCH_TO=0 disables the timeout entirely.
    localparam int unsigned     TW         = (FETCH_TO > 1) ? $clog2(FETCH_TO) : 1;
    localparam logic [TW-1:0]   FETCH_LAST = TW'((FETCH_TO == 0) ? 0 : FETCH_TO - 1);

    state_t        r_state;
    logic [7:0]    r_ctrl;
    logic [15:0]   r_remain;
    logic          r_buf_valid;
    logic [23:0]   r_buf_data;
    logic [TW-1:0] r_fetch_cnt;
    logic          r_rewind;
    logic          r_err;
    logic          r_underrun;

    state_t        w_state_nxt;
    logic [7:0]    w_ctrl_nxt;
    logic [15:0]   w_remain_nxt;
    logic          w_buf_valid_nxt;
    logic          w_buf_load;
    logic [TW-1:0] w_fetch_cnt_nxt;
    logic          w_rewind_nxt;
    logic          w_err_nxt;
    logic          w_underrun_nxt;

    logic          w_ready;
    logic          w_xfer;
    logic          w_seg_end;
    logic          w_loop;

`ifdef SCAN_SEQ_LOOP_EN
    assign w_loop = i_loop;
`else
    assign w_loop = 1'b0;
`endif

    // Prefetch only while the buffer is free and the active segment is not the LAST one.
    assign w_ready   = (r_state == ST_FETCH) ||
                       ((r_state == ST_RUN) && !r_buf_valid && !r_ctrl[7]);
    assign w_xfer    = w_ready && i_cmd_valid;
    assign w_seg_end = (r_remain == 16'd0) || (i_tick && (r_remain == 16'd1));

    // NOTE: every next-value signal gets its default first, so no path through the case infers a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_ctrl_nxt      = r_ctrl;
        w_remain_nxt    = r_remain;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_load      = 1'b0;
        w_fetch_cnt_nxt = '0;
        w_rewind_nxt    = 1'b0;
        w_err_nxt       = r_err;
        w_underrun_nxt  = r_underrun;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = ST_FETCH;
                    w_rewind_nxt   = 1'b1;
                    w_err_nxt      = 1'b0;
                    w_underrun_nxt = 1'b0;
                end
            end

            ST_FETCH: begin
                if (w_xfer) begin
                    w_state_nxt  = ST_RUN;
                    w_ctrl_nxt   = i_cmd_data[23:16];
                    w_remain_nxt = i_cmd_data[15:0];
                end else if ((FETCH_TO != 0) && (r_fetch_cnt == FETCH_LAST)) begin
                    w_state_nxt = ST_IDLE;
                    w_ctrl_nxt  = IDLE_CTRL;
                    w_err_nxt   = 1'b1;
                end else if (FETCH_TO != 0) begin
                    w_fetch_cnt_nxt = r_fetch_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (w_seg_end) begin
                    if (r_buf_valid) begin
                        w_ctrl_nxt      = r_buf_data[23:16];
                        w_remain_nxt    = r_buf_data[15:0];
                        w_buf_valid_nxt = 1'b0;
                    end else if (w_xfer) begin
                        // A word arriving on the very edge the segment ends goes straight to active.
                        w_ctrl_nxt   = i_cmd_data[23:16];
                        w_remain_nxt = i_cmd_data[15:0];
                    end else if (r_ctrl[7] && !w_loop) begin
                        w_state_nxt  = ST_DONE;
                        w_ctrl_nxt   = IDLE_CTRL;
                        w_remain_nxt = '0;
                    end else begin
                        // CtrlOut holds through the refetch; only a non-LAST end is an underrun.
                        w_state_nxt    = ST_FETCH;
                        w_remain_nxt   = '0;
                        w_rewind_nxt   = r_ctrl[7];
                        w_underrun_nxt = r_underrun | ~r_ctrl[7];
                    end
                end else begin
                    if (i_tick) begin
                        w_remain_nxt = r_remain - 16'd1;
                    end
                    if (w_xfer) begin
                        w_buf_valid_nxt = 1'b1;
                        w_buf_load      = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_ctrl_nxt  = IDLE_CTRL;
            end
        endcase

        // Abort wins over everything, including Start and a same-cycle transfer.
        if (i_abort) begin
            w_state_nxt     = ST_IDLE;
            w_ctrl_nxt      = IDLE_CTRL;
            w_remain_nxt    = '0;
            w_buf_valid_nxt = 1'b0;
            w_buf_load      = 1'b0;
            w_fetch_cnt_nxt = '0;
            w_rewind_nxt    = 1'b0;
            w_err_nxt       = r_err;
            w_underrun_nxt  = r_underrun;
        end
    end

    // NOTE: sequential state is written only with <= so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= IDLE_CTRL;
            r_remain    <= '0;
            r_buf_valid <= 1'b0;
            r_fetch_cnt <= '0;
            r_rewind    <= 1'b0;
            r_err       <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_remain    <= w_remain_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
            r_rewind    <= w_rewind_nxt;
            r_err       <= w_err_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    // NOTE: the buffer payload has no reset; r_buf_valid alone says whether it means anything.
    always_ff @(posedge i_clk) begin
        if (w_buf_load) begin
            r_buf_data <= i_cmd_data;
        end
    end

    assign o_cmd_ready  = w_ready;
    assign o_cmd_rewind = r_rewind;
    assign o_ctrl_out   = r_ctrl;
    assign o_seg_remain = r_remain;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_err        = r_err;
    assign o_underrun   = r_underrun;

    a_done_one_cycle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_done |=> !o_done);
    a_rewind_in_fetch: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_cmd_rewind |-> (r_state == ST_FETCH));
    a_buf_only_in_run: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_buf_valid |-> (r_state == ST_RUN));

endmodule

// File: tb/tb_scan_cmd_sequencer.sv
// Directed bench for scan_cmd_sequencer: a small command-store model feeds the DUT, outputs are
// compared per cycle against hand-computed tables and sequences. Define SCAN_SEQ_LOOP_EN for the loop case.
module tb_scan_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        tick;
    logic        valid;
    logic [23:0] cmd_data;
    logic        cmd_ready;
    logic        cmd_rewind;
    logic [7:0]  ctrl_out;
    logic [15:0] seg_remain;
    logic        busy;
    logic        done;
    logic        err;
    logic        underrun;
`ifdef SCAN_SEQ_LOOP_EN
    logic        loop;
`endif

    logic [23:0] mem [8];
    int          ptr;
    int          total = 0;
    int          bad   = 0;

    scan_cmd_sequencer #(
        .IDLE_CTRL (8'h00),
        .FETCH_TO  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_tick       (tick),
        .i_cmd_data   (cmd_data),
        .i_cmd_valid  (valid),
`ifdef SCAN_SEQ_LOOP_EN
        .i_loop       (loop),
`endif
        .o_cmd_ready  (cmd_ready),
        .o_cmd_rewind (cmd_rewind),
        .o_ctrl_out   (ctrl_out),
        .o_seg_remain (seg_remain),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command store: rewind presents word 0 at once and resets the read pointer at the edge.
    assign cmd_data = cmd_rewind ? mem[0] : mem[ptr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 0;
        end else if (cmd_rewind) begin
            ptr <= (valid && cmd_ready) ? 1 : 0;
        end else if (valid && cmd_ready) begin
            ptr <= (ptr < 7) ? ptr + 1 : 7;
        end
    end

    typedef struct {
        logic        s, a, t, v;
        logic [7:0]  c;
        logic [15:0] r;
        logic        b, d, rd, rw, e, u;
    } vec_t;

    vec_t vec [15];

    function automatic vec_t mk(input logic s, a, t, v, input logic [7:0] c, input logic [15:0] r,
                                input logic b, d, rd, rw, e, u);
        vec_t x;
        x.s = s;  x.a = a;  x.t = t;  x.v = v;
        x.c = c;  x.r = r;
        x.b = b;  x.d = d;  x.rd = rd; x.rw = rw; x.e = e; x.u = u;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic [7:0] c, input logic [15:0] r,
                            input logic b, d, rd, rw, e, u);
        check({tag, ".ctrl"},     32'(ctrl_out),   32'(c));
        check({tag, ".remain"},   32'(seg_remain), 32'(r));
        check({tag, ".busy"},     32'(busy),       32'(b));
        check({tag, ".done"},     32'(done),       32'(d));
        check({tag, ".ready"},    32'(cmd_ready),  32'(rd));
        check({tag, ".rewind"},   32'(cmd_rewind), 32'(rw));
        check({tag, ".err"},      32'(err),        32'(e));
        check({tag, ".underrun"}, 32'(underrun),   32'(u));
    endtask

    // Apply inputs for the current cycle, then move to the next cycle's sampling point.
    task automatic drive(input logic s, a, t, v);
        start = s;
        abort = a;
        tick  = t;
        valid = v;
        @(negedge clk);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            expect_o($sformatf("row%0d", i), vec[i].c, vec[i].r, vec[i].b, vec[i].d,
                     vec[i].rd, vec[i].rw, vec[i].e, vec[i].u);
            drive(vec[i].s, vec[i].a, vec[i].t, vec[i].v);
        end
    endtask

    task automatic load_list(input logic [23:0] w0, input logic [23:0] w1);
        for (int i = 0; i < 8; i++) mem[i] = 24'h0;
        mem[0] = w0;
        mem[1] = w1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Two-segment list, then a zero-length first segment.
        vec[0]  = mk(1,0,1,1, 8'h00, 16'd0, 0,0,0,0,0,0);
        vec[1]  = mk(0,0,1,1, 8'h00, 16'd0, 1,0,1,1,0,0);
        vec[2]  = mk(0,0,1,1, 8'h05, 16'd3, 1,0,1,0,0,0);
        vec[3]  = mk(0,0,1,1, 8'h05, 16'd2, 1,0,0,0,0,0);
        vec[4]  = mk(0,0,1,1, 8'h05, 16'd1, 1,0,0,0,0,0);
        vec[5]  = mk(0,0,1,1, 8'h86, 16'd2, 1,0,0,0,0,0);
        vec[6]  = mk(0,0,1,1, 8'h86, 16'd1, 1,0,0,0,0,0);
        vec[7]  = mk(0,0,1,1, 8'h00, 16'd0, 1,1,0,0,0,0);
        vec[8]  = mk(0,0,1,1, 8'h00, 16'd0, 0,0,0,0,0,0);
        vec[9]  = mk(1,0,1,1, 8'h00, 16'd0, 0,0,0,0,0,0);
        vec[10] = mk(0,0,1,1, 8'h00, 16'd0, 1,0,1,1,0,0);
        vec[11] = mk(0,0,1,1, 8'h11, 16'd0, 1,0,1,0,0,0);
        vec[12] = mk(0,0,1,1, 8'h92, 16'd1, 1,0,0,0,0,0);
        vec[13] = mk(0,0,1,1, 8'h00, 16'd0, 1,1,0,0,0,0);
        vec[14] = mk(0,0,0,0, 8'h00, 16'd0, 0,0,0,0,0,0);

        start = 1'b0;
        abort = 1'b0;
        tick  = 1'b0;
        valid = 1'b0;
`ifdef SCAN_SEQ_LOOP_EN
        loop  = 1'b0;
`endif
        load_list({8'h05, 16'd3}, {8'h86, 16'd2});
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_o("reset", 8'h00, 16'd0, 0,0,0,0,0,0);

        run_rows(0, 8);
        load_list({8'h11, 16'd0}, {8'h92, 16'd1});
        run_rows(9, 14);

        // Next word arrives late: underrun, CtrlOut held, second word loads on its transfer edge.
        load_list({8'h05, 16'd3}, {8'h86, 16'd2});
        drive(1,0,1,1);
        drive(0,0,1,1);
        expect_o("und.c2", 8'h05, 16'd3, 1,0,1,0,0,0);
        drive(0,0,1,0);
        drive(0,0,1,0);
        drive(0,0,1,0);
        expect_o("und.fetch", 8'h05, 16'd0, 1,0,1,0,0,1);
        drive(0,0,1,1);
        expect_o("und.load", 8'h86, 16'd2, 1,0,0,0,0,1);
        drive(0,0,1,1);
        drive(0,0,1,1);
        expect_o("und.done", 8'h00, 16'd0, 1,1,0,0,0,1);
        drive(0,0,1,1);
        expect_o("und.idle", 8'h00, 16'd0, 0,0,0,0,0,1);

        // Fetch timeout: exactly four FETCH cycles, then IDLE with Err.
        drive(1,0,1,0);
        expect_o("to.c1", 8'h00, 16'd0, 1,0,1,1,0,0);
        drive(0,0,1,0);
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("to.c%0d.busy", i), 32'(busy), 32'd1);
            drive(0,0,1,0);
        end
        expect_o("to.end", 8'h00, 16'd0, 0,0,0,0,1,0);

        // Abort mid-segment with Start high; Start held afterwards restarts with a rewind.
        load_list({8'h03, 16'd9}, {8'h84, 16'd1});
        drive(1,0,1,1);
        expect_o("ab.c1", 8'h00, 16'd0, 1,0,1,1,0,0);
        drive(0,0,1,1);
        expect_o("ab.c2", 8'h03, 16'd9, 1,0,1,0,0,0);
        drive(0,0,0,1);
        expect_o("ab.notick", 8'h03, 16'd9, 1,0,0,0,0,0);
        drive(0,0,1,1);
        drive(0,0,1,1);
        check("ab.rem7", 32'(seg_remain), 32'd7);
        drive(1,1,1,1);
        expect_o("ab.idle", 8'h00, 16'd0, 0,0,0,0,0,0);
        drive(1,0,1,1);
        expect_o("ab.restart", 8'h00, 16'd0, 1,0,1,1,0,0);
        drive(0,0,1,1);
        expect_o("ab.bufclr", 8'h03, 16'd9, 1,0,1,0,0,0);
        drive(0,1,1,1);
        expect_o("ab.idle2", 8'h00, 16'd0, 0,0,0,0,0,0);

`ifdef SCAN_SEQ_LOOP_EN
        // Loop: LAST end refetches with a rewind and no Done; dropping Loop finishes normally.
        load_list({8'h05, 16'd2}, {8'h86, 16'd1});
        loop = 1'b1;
        drive(1,0,1,1);
        drive(0,0,1,1);
        drive(0,0,1,1);
        drive(0,0,1,1);
        expect_o("lp.last", 8'h86, 16'd1, 1,0,0,0,0,0);
        drive(0,0,1,1);
        expect_o("lp.refetch", 8'h86, 16'd0, 1,0,1,1,0,0);
        loop = 1'b0;
        drive(0,0,1,1);
        expect_o("lp.again", 8'h05, 16'd2, 1,0,1,0,0,0);
        drive(0,0,1,1);
        drive(0,0,1,1);
        expect_o("lp.last2", 8'h86, 16'd1, 1,0,0,0,0,0);
        drive(0,0,1,1);
        expect_o("lp.done", 8'h00, 16'd0, 1,1,0,0,0,0);
        drive(0,0,1,1);
        expect_o("lp.idle", 8'h00, 16'd0, 0,0,0,0,0,0);
`endif

        // Asynchronous reset in the middle of a segment takes effect without a clock edge.
        load_list({8'h05, 16'd3}, {8'h86, 16'd2});
        drive(1,0,1,1);
        drive(0,0,1,1);
        drive(0,0,1,1);
        expect_o("ar.run", 8'h05, 16'd2, 1,0,0,0,0,0);
        start = 1'b0;
        valid = 1'b0;
        tick  = 1'b0;
        #2 rst_n = 1'b0;
        #1 expect_o("ar.async", 8'h00, 16'd0, 0,0,0,0,0,0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expect_o("ar.after", 8'h00, 16'd0, 0,0,0,0,0,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
